// File: rtl/dda_pkg.sv
// dda_pkg: shared definitions for the Lorenz DDA reader slice.
//   - posit word width / exponent width defaults and fixed-point format
//   - output frame constants (sync byte, frame length)
//   - streamer FSM state encoding
package dda_pkg;

  localparam int N_DEF  = 16;
  localparam int ES_DEF = 1;
  localparam int FW_DEF = 8;

  localparam logic [7:0] FRAME_SYNC = 8'hA5;
  localparam int         FRAME_LEN  = 8;
  localparam logic [2:0] IDX_LAST   = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_t;

endpackage

// File: rtl/posit_to_fixed.sv
// posit_to_fixed: combinational decode of one posit<N,ES> word into signed
// fixed point with FW fractional bits (same width N).
//   p   : posit input
//   fx  : decoded value, truncated toward zero, magnitude saturated to
//         2^(N-1)-1; NaR maps to the most negative code.
module posit_to_fixed #(
  parameter int N  = 16,
  parameter int ES = 1,
  parameter int FW = 8
) (
  input  logic [N-1:0] p,
  output logic [N-1:0] fx
);

  // Fraction bits left after the terminator and exponent in the worst case.
  localparam int FRB = N - 1 - ES;

  logic [N-2:0]  rem_s;
  logic [N-2:0]  body_s;
  logic          r0_s;
  logic          stop_s;
  logic [ES-1:0] e_s;
  logic [N-1:0]  mant_s;
  logic [N-1:0]  mag_s;
  int            run_s;
  int            k_s;
  int            scale_s;
  int            sh_s;

  // Regime/exponent/fraction extraction, scaling and saturation.
  always_comb begin
    // Magnitude of the word without the sign bit; NaR is handled separately.
    if (p[N-1]) begin
      rem_s = ~p[N-2:0] + {{(N-2){1'b0}}, 1'b1};
    end else begin
      rem_s = p[N-2:0];
    end

    r0_s   = rem_s[N-2];
    run_s  = 0;
    stop_s = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop_s && (rem_s[i] == r0_s)) begin
        run_s = run_s + 1;
      end else begin
        stop_s = 1'b1;
      end
    end

    if (r0_s) begin
      k_s = run_s - 1;
    end else begin
      k_s = -run_s;
    end

    // Drop regime run and terminator; bits shifted past the end read as zero.
    body_s  = rem_s << (run_s + 1);
    e_s     = body_s[N-2 -: ES];
    mant_s  = {{ES{1'b0}}, 1'b1, body_s[FRB-1:0]};
    scale_s = k_s * (32'sd1 << ES) + int'(e_s);
    sh_s    = scale_s + FW - FRB;

    // Hidden bit sits at FRB; it overflows the N-1 magnitude bits when sh > N-2-FRB.
    if (sh_s > (N - 2 - FRB)) begin
      mag_s = {1'b0, {(N-1){1'b1}}};
    end else if (sh_s >= 0) begin
      mag_s = mant_s << sh_s;
    end else begin
      mag_s = mant_s >> (-sh_s);
    end

    if (p == {N{1'b0}}) begin
      fx = {N{1'b0}};
    end else if (p == {1'b1, {(N-1){1'b0}}}) begin
      fx = {1'b1, {(N-1){1'b0}}};
    end else if (p[N-1]) begin
      fx = ~mag_s + {{(N-1){1'b0}}, 1'b1};
    end else begin
      fx = mag_s;
    end
  end

endmodule

// File: rtl/dda_state_streamer.sv
// dda_state_streamer: snapshots posit state x/y/z every decim-th DDA step,
// decodes each to fixed point and streams an 8-byte checksummed frame.
//   clk, rst  : clock, synchronous active-high reset
//   en        : DDA step strobe
//   x, y, z   : posit state words
//   decim     : snapshot period in steps (0 behaves as 1)
//   tx_data / tx_valid / tx_ready : byte stream, transfer on valid && ready
//   busy      : frame capture, conversion or transmission in progress
//   overrun   : sticky, a due snapshot was dropped while busy
// Frame: A5, x_hi, x_lo, y_hi, y_lo, z_hi, z_lo, XOR of the six data bytes.
module dda_state_streamer
  import dda_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int ES      = ES_DEF,
  parameter int FW      = FW_DEF,
  parameter int DECIM_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N-1:0]       x,
  input  logic [N-1:0]       y,
  input  logic [N-1:0]       z,
  input  logic [DECIM_W-1:0] decim,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overrun
);

  localparam logic [DECIM_W-1:0] CNT_ONE = {{(DECIM_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [DECIM_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]       xp_q, xp_d, yp_q, yp_d, zp_q, zp_d;
  logic [N-1:0]       fx_q, fx_d, fy_q, fy_d, fz_q, fz_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic [DECIM_W-1:0] decim_eff_s;
  logic [DECIM_W-1:0] last_s;
  logic               due_s;
  logic [N-1:0]       fx_s, fy_s, fz_s;
  logic [7:0]         csum_s;

  posit_to_fixed #(.N(N), .ES(ES), .FW(FW)) u_cvt_x (.p(xp_q), .fx(fx_s));
  posit_to_fixed #(.N(N), .ES(ES), .FW(FW)) u_cvt_y (.p(yp_q), .fx(fy_s));
  posit_to_fixed #(.N(N), .ES(ES), .FW(FW)) u_cvt_z (.p(zp_q), .fx(fz_s));

  function automatic logic [7:0] frame_byte(
    input logic [2:0]   i,
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic [N-1:0] c,
    input logic [7:0]   cs
  );
    case (i)
      3'd0:    frame_byte = FRAME_SYNC;
      3'd1:    frame_byte = a[N-1 -: 8];
      3'd2:    frame_byte = a[7:0];
      3'd3:    frame_byte = b[N-1 -: 8];
      3'd4:    frame_byte = b[7:0];
      3'd5:    frame_byte = c[N-1 -: 8];
      3'd6:    frame_byte = c[7:0];
      3'd7:    frame_byte = cs;
      default: frame_byte = 8'h00;
    endcase
  endfunction

  // Step counter and snapshot-due detection; runs independently of the FSM.
  always_comb begin
    if (decim == {DECIM_W{1'b0}}) begin
      decim_eff_s = CNT_ONE;
    end else begin
      decim_eff_s = decim;
    end
    last_s = decim_eff_s - CNT_ONE;
    // '>=' so a shrinking decim cannot leave the counter stranded above the
    // new wrap point.
    due_s = en && (cnt_q >= last_s);
    if (en) begin
      if (cnt_q >= last_s) begin
        cnt_d = {DECIM_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign csum_s = fx_q[N-1 -: 8] ^ fx_q[7:0] ^ fy_q[N-1 -: 8] ^ fy_q[7:0] ^
                  fz_q[N-1 -: 8] ^ fz_q[7:0];

  // Capture / convert / send sequencing and output byte registers.
  always_comb begin
    state_d    = state_q;
    xp_d       = xp_q;
    yp_d       = yp_q;
    zp_d       = zp_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    fz_d       = fz_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      IDLE: begin
        if (due_s) begin
          xp_d    = x;
          yp_d    = y;
          zp_d    = z;
          state_d = CONVERT;
        end else begin
          state_d = IDLE;
        end
      end
      CONVERT: begin
        fx_d    = fx_s;
        fy_d    = fy_s;
        fz_d    = fz_s;
        idx_d   = 3'd0;
        state_d = SEND;
      end
      SEND: begin
        if (!tx_valid_q) begin
          // First cycle in SEND: present the sync byte.
          tx_data_d  = frame_byte(idx_q, fx_q, fy_q, fz_q, csum_s);
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          if (idx_q == IDX_LAST) begin
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = frame_byte(idx_q + 3'd1, fx_q, fy_q, fz_q, csum_s);
          end
        end else begin
          tx_data_d  = tx_data_q;
          tx_valid_d = tx_valid_q;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);

    if (due_s && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {DECIM_W{1'b0}};
      xp_q       <= {N{1'b0}};
      yp_q       <= {N{1'b0}};
      zp_q       <= {N{1'b0}};
      fx_q       <= {N{1'b0}};
      fy_q       <= {N{1'b0}};
      fz_q       <= {N{1'b0}};
      idx_q      <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      xp_q       <= xp_d;
      yp_q       <= yp_d;
      zp_q       <= zp_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      fz_q       <= fz_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_dda_state_streamer.sv
module tb_dda_state_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] x, y, z;
  logic [7:0]  decim;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;

  logic [7:0]  exp_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dda_state_streamer dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .z(z), .decim(decim),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun)
  );

  // Reference decode using real arithmetic, posit<16,1> -> Q8.8.
  function automatic logic [15:0] model_decode(input logic [15:0] p);
    logic [15:0] a;
    int  i, run, k, e, scale, fixed;
    bit  r0;
    real frac, w, v;
    if (p == 16'h0000) return 16'h0000;
    if (p == 16'h8000) return 16'h8000;
    a = p[15] ? (16'h0000 - p) : p;
    i = 14; r0 = a[14]; run = 0;
    while (i >= 0 && a[i] == r0) begin run++; i--; end
    k = r0 ? run - 1 : -run;
    i--;
    e = 0;
    if (i >= 0) begin e = int'(a[i]); i--; end
    frac = 0.0; w = 0.5;
    while (i >= 0) begin
      if (a[i]) frac = frac + w;
      w = w / 2.0; i--;
    end
    scale = 2 * k + e;
    v = (1.0 + frac) * 256.0;
    if (scale >= 0) repeat (scale) v = v * 2.0;
    else repeat (-scale) v = v / 2.0;
    if (v >= 32767.0) fixed = 32767;
    else fixed = $rtoi(v);
    return p[15] ? 16'(-fixed) : 16'(fixed);
  endfunction

  task automatic push_frame(input logic [15:0] fa, input logic [15:0] fb, input logic [15:0] fc);
    logic [7:0] cs;
    cs = fa[15:8] ^ fa[7:0] ^ fb[15:8] ^ fb[7:0] ^ fc[15:8] ^ fc[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(fa[15:8]); exp_q.push_back(fa[7:0]);
    exp_q.push_back(fb[15:8]); exp_q.push_back(fb[7:0]);
    exp_q.push_back(fc[15:8]); exp_q.push_back(fc[7:0]);
    exp_q.push_back(cs);
  endtask

  task automatic drive_en(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    x = a; y = b; z = c; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; x = 16'h0; y = 16'h0; z = 16'h0;
    decim = 8'd1; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    decim = 8'd1; tx_ready = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h00); exp_q.push_back(8'hF4);
    drive_en(16'h4000, 16'hC000, 16'h6A00);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL basic_lat1: got %b expected 0", tx_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL basic_lat2: got %b expected 0", tx_valid); end
    @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      total++;
      if (tx_valid !== 1'b1) begin
        bad++; $display("FAIL basic_valid%0d: got %b expected 1", b, tx_valid);
      end else if (exp_q.size() == 0) begin
        bad++; $display("FAIL basic_sb_empty: got byte %h expected none", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin bad++; $display("FAIL basic_byte%0d: got %h expected %h", b, tx_data, e); end
      end
      @(negedge clk);
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL basic_end_valid: got %b expected 0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_end_busy: got %b expected 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_decode();
    logic [15:0] rx, ry, rz;
    logic [7:0]  e;
    int xf;
    tx_ready = 1'b1; decim = 8'd1;
    for (int f = 0; f < 6; f++) begin
      if (f == 0) begin
        rx = 16'h5000; ry = 16'h7FFF; rz = 16'h8000;
        push_frame(16'h0200, 16'h7FFF, 16'h8000);
      end else if (f == 1) begin
        rx = 16'h0001; ry = 16'h0000; rz = 16'h4000;
        push_frame(16'h0000, 16'h0000, 16'h0100);
      end else begin
        rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
        push_frame(model_decode(rx), model_decode(ry), model_decode(rz));
      end
      drive_en(rx, ry, rz);
      xf = 0;
      for (int c = 0; c < 30 && xf < 8; c++) begin
        if (tx_valid === 1'b1) begin
          total++;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
          if (tx_data !== e) begin bad++; $display("FAIL decode_f%0d_b%0d: got %h expected %h", f, xf, tx_data, e); end
          xf++;
        end
        @(negedge clk);
      end
      total++; if (xf != 8) begin bad++; $display("FAIL decode_count_f%0d: got %0d expected 8", f, xf); end
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    logic       pat[4];
    logic [7:0] e, prev_data;
    bit         prev_stall;
    int         xf, holds;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    decim = 8'd1; tx_ready = 1'b1;
    push_frame(model_decode(16'h6A00), model_decode(16'hC000), model_decode(16'h3123));
    drive_en(16'h6A00, 16'hC000, 16'h3123);
    xf = 0; holds = 0; prev_stall = 1'b0; prev_data = 8'h00;
    for (int c = 0; c < 60; c++) begin
      if (prev_stall) begin
        holds++;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          bad++; $display("FAIL bp_hold: got %b/%h expected 1/%h", tx_valid, tx_data, prev_data);
        end
      end
      tx_ready = pat[c % 4];
      if (tx_valid === 1'b1 && tx_ready) begin
        total++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (tx_data !== e) begin bad++; $display("FAIL bp_byte%0d: got %h expected %h", xf, tx_data, e); end
        xf++;
      end
      prev_stall = (tx_valid === 1'b1) && !tx_ready;
      prev_data  = tx_data;
      @(negedge clk);
    end
    total++; if (xf != 8) begin bad++; $display("FAIL bp_count: got %0d expected 8", xf); end
    total++; if (holds < 2) begin bad++; $display("FAIL bp_stalls: got %0d expected >=2", holds); end
    tx_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_decim4();
    logic [15:0] vx, vy, vz;
    logic [7:0]  e;
    int xf;
    decim = 8'd4; tx_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        vx = 16'h4000 + 16'(i * 16'h0100 + r);
        vy = 16'h5000 + 16'(i * 16'h0200);
        vz = 16'hB000 - 16'(i * 16'h0300);
        x = vx; y = vy; z = vz; en = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== (i == 3)) begin bad++; $display("FAIL d4_busy_r%0d_e%0d: got %b expected %b", r, i, busy, (i == 3)); end
      end
      en = 1'b0;
      push_frame(model_decode(vx), model_decode(vy), model_decode(vz));
      xf = 0;
      for (int c = 0; c < 30 && xf < 8; c++) begin
        if (tx_valid === 1'b1) begin
          total++;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
          if (tx_data !== e) begin bad++; $display("FAIL d4_r%0d_b%0d: got %h expected %h", r, xf, tx_data, e); end
          xf++;
        end
        @(negedge clk);
      end
      total++; if (xf != 8) begin bad++; $display("FAIL d4_count_r%0d: got %0d expected 8", r, xf); end
      exp_q.delete();
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL d4_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    int xf;
    decim = 8'd1; tx_ready = 1'b0;
    push_frame(16'h0100, 16'h0200, 16'hFF00);
    drive_en(16'h4000, 16'h5000, 16'hC000);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b expected 0", overrun); end
    repeat (3) @(negedge clk);
    drive_en(16'h7000, 16'h7000, 16'h7000);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    repeat (15) @(negedge clk);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      bad++; $display("FAIL ovr_held: got %b/%h expected 1/a5", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    xf = 0;
    for (int c = 0; c < 30 && xf < 8; c++) begin
      if (tx_valid === 1'b1) begin
        total++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (tx_data !== e) begin bad++; $display("FAIL ovr_b%0d: got %h expected %h", xf, tx_data, e); end
        xf++;
      end
      @(negedge clk);
    end
    total++; if (xf != 8) begin bad++; $display("FAIL ovr_count: got %0d expected 8", xf); end
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_idle: got %b expected 0", busy); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    int xf;
    decim = 8'd1; tx_ready = 1'b1;
    push_frame(model_decode(16'h5A5A), model_decode(16'h1234), model_decode(16'hE000));
    drive_en(16'h5A5A, 16'h1234, 16'hE000);
    xf = 0;
    for (int c = 0; c < 30 && xf < 3; c++) begin
      if (tx_valid === 1'b1) begin
        total++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (tx_data !== e) begin bad++; $display("FAIL rm_b%0d: got %h expected %h", xf, tx_data, e); end
        xf++;
      end
      @(negedge clk);
    end
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL rm_byte3_valid: got %b expected 1", tx_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b expected 0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b expected 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rm_overrun: got %b expected 0", overrun); end
    exp_q.delete();
    @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rm_no_resume: got %b expected 0", tx_valid); end
    push_frame(model_decode(16'h2222), model_decode(16'h9999), model_decode(16'h7F00));
    drive_en(16'h2222, 16'h9999, 16'h7F00);
    xf = 0;
    for (int c = 0; c < 30 && xf < 8; c++) begin
      if (tx_valid === 1'b1) begin
        total++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (tx_data !== e) begin bad++; $display("FAIL rm_new_b%0d: got %h expected %h", xf, tx_data, e); end
        xf++;
      end
      @(negedge clk);
    end
    total++; if (xf != 8) begin bad++; $display("FAIL rm_new_count: got %0d expected 8", xf); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_backpressure();
    test_decim4();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
